// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: control bundle between the multicycle sequencer and the MIPS datapath
// master (sequencer): inputs opcode, jr, mem_ready; outputs ALU/PC/memory/register-file controls
// slave (datapath): the mirror image of master
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       instr_done;
    modport master (
        input  opcode, jr, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, branch_ne,
               i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               illegal_op, instr_done
    );
    modport slave (
        output opcode, jr, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, branch_ne,
               i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               illegal_op, instr_done
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM sharing one ALU and one memory port
// clk: rising-edge clock; reset: asynchronous active-high, forces FETCH
// bus (master modport): opcode/jr/mem_ready in, datapath enables and mux selects out
// JAL_EN: when defined, opcode 000011 executes JAL; otherwise it is illegal
module mips_multicycle_control (
    input logic clk,
    input logic reset,
    mips_multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP
`ifdef JAL_EN
        , JAL
`endif
    } state_t;
    state_t r_state, w_next;
    logic   r_rd;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == EXEC_R) r_rd <= 1'b1;
            else if (r_state == EXEC_I) r_rd <= 1'b0;
        end
    end
    always_comb begin
        w_next            = r_state;
        bus.alu_op        = 4'b0000;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.pc_source     = 2'b00;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.reg_write     = 1'b0;
        bus.illegal_op    = 1'b0;
        bus.instr_done    = 1'b0;
        case (r_state)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 4'b0010;
                w_next        = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.alu_op    = 4'b0011;
                case (bus.opcode)
                    6'b000000:                                  w_next = EXEC_R;
                    6'b001000, 6'b001101, 6'b001100, 6'b001111: w_next = EXEC_I;
                    6'b100011, 6'b101011:                       w_next = MEM_ADDR;
                    6'b000100, 6'b000101:                       w_next = BRANCH;
                    6'b000010:                                  w_next = JUMP;
`ifdef JAL_EN
                    6'b000011:                                  w_next = JAL;
`endif
                    default: begin
                        w_next         = FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = 4'b0111;
                bus.pc_write   = bus.jr;
                bus.pc_source  = bus.jr ? 2'b11 : 2'b00;
                bus.instr_done = bus.jr;
                w_next         = bus.jr ? FETCH : ALU_WB;
            end
            EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = bus.opcode == 6'b001000 ? 4'b0100 :
                                bus.opcode == 6'b001101 ? 4'b0101 :
                                bus.opcode == 6'b001100 ? 4'b0110 : 4'b1000;
                w_next        = ALU_WB;
            end
            ALU_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = {1'b0, r_rd};
                bus.instr_done = 1'b1;
                w_next         = FETCH;
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = bus.opcode == 6'b100011 ? 4'b0010 : 4'b0011;
                w_next        = bus.opcode == 6'b100011 ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
                w_next       = bus.mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
                bus.instr_done = 1'b1;
                w_next         = FETCH;
            end
            MEM_WRITE: begin
                bus.i_or_d     = 1'b1;
                bus.mem_write  = 1'b1;
                bus.instr_done = bus.mem_ready;
                w_next         = bus.mem_ready ? FETCH : MEM_WRITE;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 4'b0001;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                bus.branch_ne     = bus.opcode == 6'b000101;
                bus.instr_done    = 1'b1;
                w_next            = FETCH;
            end
            JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 2'b10;
                bus.instr_done = 1'b1;
                w_next         = FETCH;
            end
`ifdef JAL_EN
            JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 2'b10;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b10;
                bus.mem_to_reg = 2'b10;
                bus.instr_done = 1'b1;
                w_next         = FETCH;
            end
`endif
            default: w_next = FETCH;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: scoreboard bench for the multicycle MIPS control FSM
// Expected per-cycle control vectors are queued per instruction, then drained and compared at negedge.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mips_multicycle_control_if bus();
    mips_multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));
    logic [22:0] outv;
    assign outv = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_source, bus.pc_write,
                   bus.pc_write_cond, bus.branch_ne, bus.i_or_d, bus.mem_read, bus.mem_write,
                   bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal_op,
                   bus.instr_done};
    // field masks: selects are only checked where the state defines them
    localparam logic [22:0] M_ALU = 23'h7F0000;
    localparam logic [22:0] M_PCS = 23'h00C000;
    localparam logic [22:0] M_EN  = 23'h003F87;
    localparam logic [22:0] M_WB  = 23'h000078;
    localparam logic [22:0] M_ALL = 23'h7FFFFF;
    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic        jr;
        logic [22:0] exp;
        logic [22:0] msk;
        string       nm;
    } item_t;
    item_t sb[$];
    // field order: alu_op, src_a, src_b, pc_source, {pcw,pcwc,bne,iord,mr,mw,irw}, reg_dst, mem_to_reg, {rw,ill,done}
    function automatic logic [22:0] f_fetch(input logic r);
        return {4'b0010, 1'b0, 2'b01, 2'b00, r, 3'b000, 1'b1, 1'b0, r, 2'b00, 2'b00, 3'b000};
    endfunction
    function automatic logic [22:0] f_dec(input logic ill);
        return {4'b0011, 1'b0, 2'b11, 2'b00, 7'b0, 2'b00, 2'b00, 1'b0, ill, 1'b0};
    endfunction
    function automatic logic [22:0] f_xr(input logic j);
        return {4'b0111, 1'b1, 2'b00, j ? 2'b11 : 2'b00, j, 6'b0, 2'b00, 2'b00, 2'b00, j};
    endfunction
    function automatic logic [22:0] f_xi(input logic [3:0] a);
        return {a, 1'b1, 2'b10, 2'b00, 7'b0, 4'b0, 3'b000};
    endfunction
    function automatic logic [22:0] f_awb(input logic [1:0] rd);
        return {9'b0, 2'b00, 7'b0, rd, 2'b00, 3'b101};
    endfunction
    function automatic logic [22:0] f_ma(input logic lw);
        return {lw ? 4'b0010 : 4'b0011, 1'b1, 2'b10, 2'b00, 7'b0, 4'b0, 3'b000};
    endfunction
    function automatic logic [22:0] f_mr();
        return {9'b0, 7'b0001100, 4'b0, 3'b000};
    endfunction
    function automatic logic [22:0] f_mwb();
        return {9'b0, 7'b0, 2'b00, 2'b01, 3'b101};
    endfunction
    function automatic logic [22:0] f_mw(input logic r);
        return {9'b0, 7'b0001010, 4'b0, 2'b00, r};
    endfunction
    function automatic logic [22:0] f_br(input logic ne);
        return {4'b0001, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, ne, 4'b0, 4'b0, 3'b001};
    endfunction
    function automatic logic [22:0] f_j();
        return {7'b0, 2'b10, 7'b1000000, 4'b0, 3'b001};
    endfunction
    function automatic logic [22:0] f_jal();
        return {7'b0, 2'b10, 7'b1000000, 2'b10, 2'b10, 3'b101};
    endfunction
    task automatic push(input logic [5:0] op, input logic mr, input logic jr,
                        input logic [22:0] e, input logic [22:0] m, input string nm);
        sb.push_back('{op, mr, jr, e, m, nm});
    endtask
    // queue the full expected cycle sequence of one instruction
    task automatic push_instr(input logic [5:0] op, input logic jr, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(op, 1'b0, 1'b0, f_fetch(1'b0), M_ALU | M_PCS | M_EN, "fetch_wait");
        push(op, 1'b1, 1'b0, f_fetch(1'b1), M_ALU | M_PCS | M_EN, "fetch");
        case (op)
            6'b000000, 6'b001000, 6'b001101, 6'b001100, 6'b001111, 6'b100011, 6'b101011,
            6'b000100, 6'b000101, 6'b000010
`ifdef JAL_EN
            , 6'b000011
`endif
            : push(op, 1'b1, 1'b0, f_dec(1'b0), M_ALU | M_EN, "decode");
            default: push(op, 1'b1, 1'b0, f_dec(1'b1), M_ALU | M_EN, "illegal");
        endcase
        case (op)
            6'b000000: begin
                push(op, 1'b1, jr, f_xr(jr), M_ALU | M_EN | (jr ? M_PCS : 23'h0), jr ? "jr" : "exec_r");
                if (!jr) push(op, 1'b1, 1'b0, f_awb(2'b01), M_EN | M_WB, "wb_r");
            end
            6'b001000, 6'b001101, 6'b001100, 6'b001111: begin
                push(op, 1'b1, 1'b0, f_xi(op == 6'b001000 ? 4'b0100 : op == 6'b001101 ? 4'b0101 :
                                           op == 6'b001100 ? 4'b0110 : 4'b1000), M_ALU | M_EN, "exec_i");
                push(op, 1'b1, 1'b0, f_awb(2'b00), M_EN | M_WB, "wb_i");
            end
            6'b100011: begin
                push(op, 1'b1, 1'b0, f_ma(1'b1), M_ALU | M_EN, "addr_lw");
                for (int i = 0; i < mw; i++) push(op, 1'b0, 1'b0, f_mr(), M_EN, "mem_read_wait");
                push(op, 1'b1, 1'b0, f_mr(), M_EN, "mem_read");
                push(op, 1'b1, 1'b0, f_mwb(), M_EN | M_WB, "mem_wb");
            end
            6'b101011: begin
                push(op, 1'b1, 1'b0, f_ma(1'b0), M_ALU | M_EN, "addr_sw");
                for (int i = 0; i < mw; i++) push(op, 1'b0, 1'b0, f_mw(1'b0), M_EN, "mem_write_wait");
                push(op, 1'b1, 1'b0, f_mw(1'b1), M_EN, "mem_write");
            end
            6'b000100, 6'b000101: push(op, 1'b1, 1'b0, f_br(op[0]), M_ALU | M_PCS | M_EN, "branch");
            6'b000010: push(op, 1'b1, 1'b0, f_j(), M_PCS | M_EN, "jump");
`ifdef JAL_EN
            6'b000011: push(op, 1'b1, 1'b0, f_jal(), M_PCS | M_EN | M_WB, "jal");
`endif
            default: ;
        endcase
    endtask
    task automatic test_reset();
        item_t it;
        bus.opcode    = 6'b000000;
        bus.jr        = 1'b0;
        bus.mem_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outv !== f_fetch(1'b0)) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", outv, f_fetch(1'b0));
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_instr(6'b000000, 1'b0, 0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.jr = it.jr; bus.mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if ((outv & it.msk) !== (it.exp & it.msk)) begin
                errors++;
                $display("FAIL reset_%s: got %h want %h mask %h", it.nm, outv & it.msk, it.exp & it.msk, it.msk);
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_alu();
        item_t it;
        push_instr(6'b000000, 1'b0, 0, 0);
        push_instr(6'b001000, 1'b0, 1, 0);
        push_instr(6'b001101, 1'b0, 0, 0);
        push_instr(6'b001100, 1'b0, 0, 0);
        push_instr(6'b001111, 1'b0, 2, 0);
        push_instr(6'b000000, 1'b0, 0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.jr = it.jr; bus.mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if ((outv & it.msk) !== (it.exp & it.msk)) begin
                errors++;
                $display("FAIL alu_%s op=%b: got %h want %h mask %h", it.nm, it.op, outv & it.msk, it.exp & it.msk, it.msk);
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_mem();
        item_t it;
        push_instr(6'b100011, 1'b0, 0, 2);
        push_instr(6'b101011, 1'b0, 0, 0);
        push_instr(6'b101011, 1'b0, 1, 3);
        push_instr(6'b100011, 1'b0, 0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.jr = it.jr; bus.mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if ((outv & it.msk) !== (it.exp & it.msk)) begin
                errors++;
                $display("FAIL mem_%s op=%b: got %h want %h mask %h", it.nm, it.op, outv & it.msk, it.exp & it.msk, it.msk);
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_flow();
        item_t it;
        push_instr(6'b000100, 1'b0, 0, 0);
        push_instr(6'b000101, 1'b0, 0, 0);
        push_instr(6'b000010, 1'b0, 0, 0);
        push_instr(6'b000000, 1'b1, 0, 0);
        push_instr(6'b000000, 1'b0, 0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.jr = it.jr; bus.mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if ((outv & it.msk) !== (it.exp & it.msk)) begin
                errors++;
                $display("FAIL flow_%s op=%b: got %h want %h mask %h", it.nm, it.op, outv & it.msk, it.exp & it.msk, it.msk);
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_illegal();
        item_t it;
        push_instr(6'b000011, 1'b0, 0, 0);
        push_instr(6'b111111, 1'b0, 0, 0);
        push_instr(6'b010000, 1'b0, 0, 0);
        push_instr(6'b001000, 1'b0, 0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.jr = it.jr; bus.mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if ((outv & it.msk) !== (it.exp & it.msk)) begin
                errors++;
                $display("FAIL illegal_%s op=%b: got %h want %h mask %h", it.nm, it.op, outv & it.msk, it.exp & it.msk, it.msk);
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_back_to_back();
        item_t it;
        logic [5:0] ops [12] = '{6'b000000, 6'b001000, 6'b001101, 6'b001100, 6'b001111, 6'b100011,
                                 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b110000};
        for (int n = 0; n < 30; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 11)];
            push_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.jr = it.jr; bus.mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if ((outv & it.msk) !== (it.exp & it.msk)) begin
                errors++;
                $display("FAIL b2b_%s op=%b: got %h want %h mask %h", it.nm, it.op, outv & it.msk, it.exp & it.msk, it.msk);
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_reset_mid();
        item_t it;
        push(6'b100011, 1'b1, 1'b0, f_fetch(1'b1), M_ALU | M_PCS | M_EN, "fetch");
        push(6'b100011, 1'b1, 1'b0, f_dec(1'b0), M_ALU | M_EN, "decode");
        push(6'b100011, 1'b1, 1'b0, f_ma(1'b1), M_ALU | M_EN, "addr_lw");
        push(6'b100011, 1'b0, 1'b0, f_mr(), M_EN, "mem_read_wait");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.jr = it.jr; bus.mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if ((outv & it.msk) !== (it.exp & it.msk)) begin
                errors++;
                $display("FAIL rstmid_%s: got %h want %h mask %h", it.nm, outv & it.msk, it.exp & it.msk, it.msk);
            end
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outv !== f_fetch(1'b0)) begin
            errors++;
            $display("FAIL rstmid_async: got %h want %h", outv, f_fetch(1'b0));
        end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_instr(6'b100011, 1'b0, 0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.jr = it.jr; bus.mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if ((outv & it.msk) !== (it.exp & it.msk)) begin
                errors++;
                $display("FAIL rstmid_after_%s: got %h want %h mask %h", it.nm, outv & it.msk, it.exp & it.msk, it.msk);
            end
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_flow();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
